// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit:
// operation encodings, controller states and iteration count.
package muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_seq_addsub_33.sv
// Shared add/subtract stage: a + (sub ? ~b : b) + sub, with the carry-out
// returned as the top bit of sum.
module addsub_33 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W:0]   sum
);

  logic [W-1:0] b_eff;

  always_comb begin
    b_eff = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit producing HI/LO in 33 cycles:
// one radix-2 step per cycle through a single shared add/subtract stage.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [WIDTH-1:0]   ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE2 = {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Control state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;

  // Datapath: r = accumulator / partial remainder,
  //           x = multiplier / dividend-then-quotient,
  //           y = multiplicand / divisor.
  op_e              op_q,    op_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             dz_q,    dz_d;
  logic [WIDTH-1:0] r_q,     r_d;
  logic [WIDTH-1:0] x_q,     x_d;
  logic [WIDTH-1:0] y_q,     y_d;

  logic [WIDTH-1:0] add_a;
  logic             add_sub;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] rem_shift;

  op_e                op_in;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               div_ok;
  logic [WIDTH:0]     prod;
  logic [2*WIDTH-1:0] p_neg;

  addsub_33 #(.W(WIDTH)) u_addsub (
    .a   (add_a),
    .b   (y_q),
    .sub (add_sub),
    .sum (add_sum)
  );

  always_comb begin
    rem_shift = {r_q[WIDTH-2:0], x_q[WIDTH-1]};
    if (op_is_div(op_q)) begin
      add_a   = rem_shift;
      add_sub = 1'b1;
    end else begin
      add_a   = r_q;
      add_sub = 1'b0;
    end
  end

  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    dz_d    = dz_q;
    r_d     = r_q;
    x_d     = x_q;
    y_d     = y_q;
    op_in   = op_e'(op);
    a_mag   = a;
    b_mag   = b;
    div_ok  = 1'b0;
    prod    = '0;
    p_neg   = '0;

    unique case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          op_d    = op_in;
          a_neg_d = op_is_signed(op_in) & a[WIDTH-1];
          b_neg_d = op_is_signed(op_in) & b[WIDTH-1];
          a_mag   = a_neg_d ? (~a + ONE) : a;
          b_mag   = b_neg_d ? (~b + ONE) : b;
          dz_d    = op_is_div(op_in) && (b == '0);
          r_d     = '0;
          if (op_is_div(op_in)) begin
            x_d = a_mag;
            y_d = b_mag;
          end else begin
            x_d = b_mag;
            y_d = a_mag;
          end
          count_d = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        if (op_is_div(op_q)) begin
          // A set bit shifted out of r means the 33-bit partial remainder
          // already exceeds any 32-bit divisor, so the subtract must succeed.
          div_ok = add_sum[WIDTH] | r_q[WIDTH-1];
          r_d    = div_ok ? add_sum[WIDTH-1:0] : rem_shift;
          x_d    = {x_q[WIDTH-2:0], div_ok};
        end else begin
          prod = x_q[0] ? add_sum : {1'b0, r_q};
          r_d  = prod[WIDTH:1];
          x_d  = {prod[0], x_q[WIDTH-1:1]};
        end
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(ITER - 1)) state_d = FIX;
      end

      FIX: begin
        if (op_is_div(op_q)) begin
          // Divide by zero leaves quotient all-ones and r = |a|, so the
          // dividend-sign fixup of r restores the raw dividend in hi.
          lo_d = dz_q ? '1 : ((a_neg_q ^ b_neg_q) ? (~x_q + ONE) : x_q);
          hi_d = a_neg_q ? (~r_q + ONE) : r_q;
        end else begin
          p_neg = ~{r_q, x_q} + ONE2;
          {hi_d, lo_d} = (a_neg_q ^ b_neg_q) ? p_neg : {r_q, x_q};
        end
        done_d  = 1'b1;
        count_d = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // NOTE: operand registers are left unreset; they are always loaded by an accepted start before use.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    a_neg_q <= a_neg_d;
    b_neg_q <= b_neg_d;
    dz_q    <= dz_d;
    r_q     <= r_d;
    x_q     <= x_d;
    y_q     <= y_d;
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: arithmetic reference model compared
// every cycle, plus directed vectors with hand-computed HI/LO values.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        hi_we, lo_we;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  // Reference model state
  int          m_cnt;
  logic        m_done;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Returns {hi, lo} for one operation, straight from integer arithmetic.
  function automatic logic [63:0] model_result(input logic [1:0] o,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
    longint      sx, sy, sq, sr;
    logic [63:0] ux, uy, up;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      2'b00:   up = sx * sy;
      2'b01:   up = ux * uy;
      2'b10: begin
        if (y == 32'h0) up = {x, 32'hFFFF_FFFF};
        else begin
          sq = sx / sy;
          sr = sx % sy;
          up = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (y == 32'h0) up = {x, 32'hFFFF_FFFF};
        else            up = {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
    return up;
  endfunction

  always @(posedge clk) begin
    logic [63:0] res;
    if (rst) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_hi   = 32'h0;
      m_lo   = 32'h0;
    end else begin
      m_done = 1'b0;
      if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi   = p_hi;
          m_lo   = p_lo;
          m_done = 1'b1;
        end
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
        if (start) begin
          res   = model_result(op, a, b);
          p_hi  = res[63:32];
          p_lo  = res[31:0];
          m_cnt = 33;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("cyc busy", {31'h0, busy}, {31'h0, m_cnt != 0});
      check("cyc done", {31'h0, done}, {31'h0, m_done});
      check("cyc hi", hi, m_hi);
      check("cyc lo", lo, m_lo);
    end
  end

  // Called at a negedge; drives start immediately, waits for done (bounded).
  // poke_kind 1: start pulse at poke_at, 2: hi_we pulse at poke_at.
  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int poke_at = -1, input int poke_kind = 0);
    int cyc;
    int busy_cyc;
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lo_we = 1'b0;
    cyc = 0;
    busy_cyc = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cyc++;
      if (cyc == poke_at) begin
        if (poke_kind == 1) begin
          start = 1'b1; op = 2'b11; a = 32'h1; b = 32'h1;
        end else if (poke_kind == 2) begin
          hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        end
      end
      @(negedge clk);
      start = 1'b0;
      hi_we = 1'b0;
      cyc++;
    end
    check({nm, " latency"}, cyc, 33);
    check({nm, " busy cycles"}, busy_cyc, 33);
    check({nm, " hi"}, hi, ehi);
    check({nm, " lo"}, lo, elo);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

    // MTHI / MTLO in IDLE
    hi_we = 1'b1; wdata = 32'h1111_1111;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h2222_2222;
    @(negedge clk);
    lo_we = 1'b0;
    check("mthi", hi, 32'h1111_1111);
    check("mtlo", lo, 32'h2222_2222);

    run_op("mult_m3x5",     2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_min_sq",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("mult_7xm6",     2'b00, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
    run_op("divu_7_2",      2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);
    run_op("div_m7_2",      2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2",      2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_min_m1",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_5_0",      2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF);
    run_op("div_m5_0",      2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("divu_big_div",  2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0001);
    run_op("start_ignored", 2'b01, 32'd100,       32'd200,       32'h0000_0000, 32'h0000_4E20, 5, 1);
    run_op("hi_we_busy",    2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 7, 2);

    lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    run_op("lo_we_start",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);

    // Reset in the middle of an operation
    op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", {31'h0, busy}, 32'h0);
    check("midrst done", {31'h0, done}, 32'h0);
    check("midrst hi", hi, 32'h0);
    check("midrst lo", lo, 32'h0);

    run_op("multu_2x3",     2'b01, 32'd2,         32'd3,         32'h0000_0000, 32'h0000_0006);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
